// File: rtl/muxword_arb.sv
// muxword_arb: N-channel valid/ready word arbiter (round-robin or fixed priority)
// feeding a one-entry registered output stage with valid/ready backpressure.
module muxword_arb #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 64,
    parameter bit RR    = 1'b1,
    parameter int IDW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [N_CH-1:0]            in_valid,
    input  logic [N_CH-1:0][WIDTH-1:0] in_data,
    output logic [N_CH-1:0]            in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDW-1:0]             out_id,
    input  logic                       out_ready
);

    localparam logic [IDW-1:0] LAST_CH = IDW'(N_CH - 1);
    localparam logic [IDW:0]   N_WIDE  = (IDW + 1)'(N_CH);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic           grant_valid;
    logic           load;
    logic           xfer;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;

    // The output stage can take a word when empty or being drained this cycle.
    assign load = reset && !flush && (!out_valid || out_ready);
    assign xfer = load && grant_valid;

    // Scan candidates starting at ptr (round-robin) or at 0 (fixed priority);
    // the wrap is an explicit subtract so non-power-of-2 channel counts work.
    always_comb begin : arbitrate
        // NOTE: blocking assignments here so each loop iteration sees the
        // grant_valid decided by the earlier ones; state registers use <=.
        grant_valid = 1'b0;
        grant       = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (RR) begin
                scan_sum = {1'b0, ptr} + (IDW + 1)'(k);
                if (scan_sum >= N_WIDE) begin
                    scan_sum = scan_sum - N_WIDE;
                end
                scan_idx = scan_sum[IDW-1:0];
            end else begin
                scan_idx = IDW'(k);
            end
            if (!grant_valid && in_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant       = scan_idx;
            end
        end
    end

    always_comb begin : ready_decode
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant];
                out_id    <= grant;
            end else if (flush || out_ready) begin
                // Data and id hold; they are meaningless once out_valid drops.
                out_valid <= 1'b0;
            end
            if (RR && xfer) begin
                ptr <= (grant == LAST_CH) ? '0 : grant + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_muxword_arb.sv
// Self-checking bench for muxword_arb: three instances (4-ch RR, 4-ch fixed,
// 3-ch RR) compared every cycle against a modulo-arithmetic reference model.
module tb_muxword_arb;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic             reset;
    logic             flush;
    logic             out_ready;
    logic [3:0]       in_valid4;
    logic [3:0][63:0] in_data4;
    logic [2:0]       in_valid3;
    logic [2:0][63:0] in_data3;

    logic [3:0]  a_in_ready, b_in_ready;
    logic [2:0]  c_in_ready;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic [63:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]  a_out_id, b_out_id, c_out_id;

    muxword_arb #(.N_CH(4), .WIDTH(64), .RR(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_id(a_out_id),
        .out_ready(out_ready)
    );

    muxword_arb #(.N_CH(4), .WIDTH(64), .RR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_id(b_out_id),
        .out_ready(out_ready)
    );

    muxword_arb #(.N_CH(3), .WIDTH(64), .RR(1'b1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_id(c_out_id),
        .out_ready(out_ready)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, one entry per instance.
    bit          m_valid [3] = '{0, 0, 0};
    logic [63:0] m_data  [3] = '{0, 0, 0};
    int          m_id    [3] = '{0, 0, 0};
    int          m_ptr   [3] = '{0, 0, 0};

    function automatic int nch(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit rr_mode(input int d);
        return d != 1;
    endfunction

    function automatic logic [3:0] cur_valid(input int d);
        return (d < 2) ? in_valid4 : {1'b0, in_valid3};
    endfunction

    function automatic logic [63:0] cur_data(input int d, input int g);
        return (d < 2) ? in_data4[g[1:0]] : in_data3[g[1:0]];
    endfunction

    // First requesting channel in scan order, or -1 when nobody requests.
    function automatic int exp_grant(input int d);
        logic [3:0] v = cur_valid(d);
        for (int k = 0; k < nch(d); k++) begin
            int i = rr_mode(d) ? (m_ptr[d] + k) % nch(d) : k;
            if (v[i[1:0]]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int d);
        int g = exp_grant(d);
        if (g < 0 || reset !== 1'b1 || flush || (m_valid[d] && !out_ready))
            return 4'b0000;
        return 4'(1 << g);
    endfunction

    function automatic logic [3:0] obs_ready(input int d);
        case (d)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return {1'b0, c_in_ready};
        endcase
    endfunction

    // {valid, id, data}; id and data are masked while valid is low.
    function automatic logic [66:0] obs_out(input int d);
        case (d)
            0:       return a_out_valid ? {1'b1, a_out_id, a_out_data} : 67'd0;
            1:       return b_out_valid ? {1'b1, b_out_id, b_out_data} : 67'd0;
            default: return c_out_valid ? {1'b1, c_out_id, c_out_data} : 67'd0;
        endcase
    endfunction

    function automatic logic [66:0] exp_out(input int d);
        logic [31:0] id = m_id[d];
        return m_valid[d] ? {1'b1, id[1:0], m_data[d]} : 67'd0;
    endfunction

    // Advance one clock: decide transfers from pre-edge inputs, then update model.
    task automatic tick();
        int          g   [3];
        bit          go  [3];
        logic [63:0] dsel[3];
        bit rst_n = (reset === 1'b1);
        bit fl    = flush;
        bit ordy  = out_ready;
        for (int d = 0; d < 3; d++) begin
            g[d]    = exp_grant(d);
            go[d]   = (exp_ready(d) != 4'b0000);
            dsel[d] = go[d] ? cur_data(d, g[d]) : 64'd0;
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_data[d]  = 64'd0;
                m_id[d]    = 0;
                m_ptr[d]   = 0;
            end else if (go[d]) begin
                m_valid[d] = 1'b1;
                m_data[d]  = dsel[d];
                m_id[d]    = g[d];
                if (rr_mode(d)) m_ptr[d] = (g[d] + 1) % nch(d);
            end else if (fl || ordy) begin
                m_valid[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid4 = 4'hF;
        in_valid3 = 3'b111;
        in_data4  = '1;
        in_data3  = '1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (obs_ready(d) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_in_ready dut%0d got %b want 0000", d, obs_ready(d));
            end
        end
        tests_run++;
        if ({a_out_valid, a_out_data, a_out_id} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_out_a got v=%b d=%h id=%0d want all zero",
                     a_out_valid, a_out_data, a_out_id);
        end
        tests_run++;
        if ({c_out_valid, c_out_data, c_out_id} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_out_c got v=%b d=%h id=%0d want all zero",
                     c_out_valid, c_out_data, c_out_id);
        end
        in_valid4 = 4'h0;
        in_valid3 = 3'b000;
        reset     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (obs_out(d) !== 67'd0) begin
                    tests_failed++;
                    $display("FAIL idle_after_reset dut%0d got %h want 0", d, obs_out(d));
                end
            end
        end
    endtask

    task automatic test_rr_fairness();
        for (int i = 0; i < 4; i++) in_data4[i] = 64'h100 + 64'(i);
        for (int i = 0; i < 3; i++) in_data3[i] = 64'h300 + 64'(i);
        in_valid4 = 4'hF;
        in_valid3 = 3'b111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            tests_run++;
            if (a_in_ready !== 4'(1 << (c % 4))) begin
                tests_failed++;
                $display("FAIL rr_in_ready cyc%0d got %b want %b", c, a_in_ready, 4'(1 << (c % 4)));
            end
            tick();
            tests_run++;
            if (!a_out_valid || a_out_id !== 2'(c % 4) || a_out_data !== 64'h100 + 64'(c % 4)) begin
                tests_failed++;
                $display("FAIL rr_sequence cyc%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         c, a_out_valid, a_out_id, a_out_data, c % 4, 64'h100 + 64'(c % 4));
            end
            tests_run++;
            if (c_out_id !== 2'(c % 3) || b_out_id !== 2'd0) begin
                tests_failed++;
                $display("FAIL rr_other_ids cyc%0d got c=%0d b=%0d want c=%0d b=0",
                         c, c_out_id, b_out_id, c % 3);
            end
        end
    endtask

    task automatic test_fixed_priority();
        in_valid4 = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (!b_out_valid || b_out_id !== 2'd1 || b_out_data !== 64'h101) begin
                tests_failed++;
                $display("FAIL fixed_prio cyc%0d got v=%b id=%0d want v=1 id=1",
                         c, b_out_valid, b_out_id);
            end
        end
        in_valid4 = 4'b1000;
        tick();
        tests_run++;
        if (!b_out_valid || b_out_id !== 2'd3 || b_out_data !== 64'h103) begin
            tests_failed++;
            $display("FAIL fixed_prio_drop got v=%b id=%0d want v=1 id=3", b_out_valid, b_out_id);
        end
        tests_run++;
        if (obs_out(0) !== exp_out(0)) begin
            tests_failed++;
            $display("FAIL fixed_prio_rr_side got %h want %h", obs_out(0), exp_out(0));
        end
    endtask

    task automatic test_backpressure();
        in_valid4 = 4'h0;
        in_valid3 = 3'b000;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) in_data4[i] = 64'hDEAD;
        in_valid4 = 4'hF;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) in_data4[i] = 64'h200 + 64'(i);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (a_in_ready !== 4'b0000 || b_in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_in_ready cyc%0d got a=%b b=%b want 0000", c, a_in_ready, b_in_ready);
            end
            tick();
            tests_run++;
            if (!a_out_valid || a_out_data !== 64'hDEAD) begin
                tests_failed++;
                $display("FAIL bp_hold cyc%0d got v=%b d=%h want v=1 d=dead", c, a_out_valid, a_out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (a_in_ready !== exp_ready(0) || a_in_ready === 4'b0000) begin
            tests_failed++;
            $display("FAIL bp_release_ready got %b want %b", a_in_ready, exp_ready(0));
        end
        tick();
        tests_run++;
        if (!a_out_valid || a_out_data !== 64'h200 + 64'(m_id[0]) || obs_out(0) !== exp_out(0)) begin
            tests_failed++;
            $display("FAIL bp_no_bubble got %h want %h", obs_out(0), exp_out(0));
        end
    endtask

    task automatic test_ptr_wrap();
        in_valid4 = 4'h0;
        in_valid3 = 3'b000;
        out_ready = 1'b1;
        tick();
        in_valid3 = 3'b010;
        tick();
        in_valid3 = 3'b011;
        #1;
        tests_run++;
        if (c_in_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL wrap_grant0 got %b want 001", c_in_ready);
        end
        tick();
        tests_run++;
        if (!c_out_valid || c_out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL wrap_id0 got v=%b id=%0d want v=1 id=0", c_out_valid, c_out_id);
        end
        #1;
        tests_run++;
        if (c_in_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL wrap_grant1 got %b want 010", c_in_ready);
        end
        tick();
        tests_run++;
        if (!c_out_valid || c_out_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL wrap_id1 got v=%b id=%0d want v=1 id=1", c_out_valid, c_out_id);
        end
    endtask

    task automatic test_flush();
        int mp;
        in_valid4 = 4'hF;
        in_valid3 = 3'b111;
        out_ready = 1'b0;
        tick();
        mp        = m_ptr[0];
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (obs_ready(d) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL flush_in_ready dut%0d got %b want 0000", d, obs_ready(d));
            end
        end
        tick();
        flush = 1'b0;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (obs_out(d) !== 67'd0) begin
                tests_failed++;
                $display("FAIL flush_clear dut%0d got %h want 0", d, obs_out(d));
            end
        end
        #1;
        tests_run++;
        if (a_in_ready !== 4'(1 << mp)) begin
            tests_failed++;
            $display("FAIL flush_ptr_kept got %b want %b", a_in_ready, 4'(1 << mp));
        end
        tick();
        tests_run++;
        if (!a_out_valid || a_out_id !== 2'(mp)) begin
            tests_failed++;
            $display("FAIL flush_resume got v=%b id=%0d want v=1 id=%0d", a_out_valid, a_out_id, mp);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(63) != 0);
            flush     = ($urandom_range(31) == 0);
            out_ready = ($urandom_range(3) != 0);
            in_valid4 = 4'($urandom);
            in_valid3 = 3'($urandom);
            for (int i = 0; i < 4; i++) in_data4[i] = {$urandom, $urandom};
            for (int i = 0; i < 3; i++) in_data3[i] = {$urandom, $urandom};
            #1;
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (obs_ready(d) !== exp_ready(d)) begin
                    tests_failed++;
                    $display("FAIL rand_in_ready cyc%0d dut%0d got %b want %b",
                             c, d, obs_ready(d), exp_ready(d));
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (obs_out(d) !== exp_out(d)) begin
                    tests_failed++;
                    $display("FAIL rand_out cyc%0d dut%0d got %h want %h",
                             c, d, obs_out(d), exp_out(d));
                end
            end
        end
        reset = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_ptr_wrap();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muxword_arb.md
Name: muxword_arb

Overview:
- N-channel successor of the 2:1 word select.
- Picks one of N_CH valid/ready word sources per cycle, using round-robin or fixed-priority arbitration.
- Registers the winning word and its source index in a one-entry output stage with valid/ready backpressure.
- Sits in the pipeline wherever several producers share one consumer, e.g. writeback-source or memory-request merging.

Parameters:
- N_CH, 4: number of input channels; legal range 1..16.
- WIDTH, 64: data width in bits; word_t when 64.
- RR, 1: arbitration mode. 1 = round-robin; 0 = fixed priority, lowest index wins.
- IDW, (N_CH>1 ? $clog2(N_CH) : 1): derived width of out_id; not overridden by users.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- flush  in  1  synchronous clear of the output stage; active-high.
- in_valid  in  N_CH  per-channel request.
- in_data  in  N_CH x WIDTH  per-channel data word.
- in_ready  out  N_CH  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  output stage holds a word.
- out_data  out  WIDTH  registered winning word.
- out_id  out  IDW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the output word.

Behaviour:
- Reset (reset==0 at clk edge): out_valid=0, out_data=0, out_id=0, RR pointer ptr=0. in_ready is combinationally 0 while reset==0.
- Load enable: load = reset && !flush && (!out_valid || out_ready). Full throughput is one word per cycle when out_ready is held high.
- Grant, combinational:
  - RR=1: first i with in_valid[i], scanning ptr, ptr+1, ..., wrapping mod N_CH.
  - RR=0: lowest i with in_valid[i].
  - No valid input: no grant.
- in_ready[i] = load && grant==i. in_ready depends combinationally on in_valid, out_valid and out_ready. Sources must not make in_valid depend on in_ready.
- Transfer on channel g (in_valid[g] && in_ready[g]): next cycle out_valid=1, out_data=in_data[g], out_id=g. Latency is exactly 1 cycle.
- RR pointer:
  - On a transfer from g, ptr <= (g==N_CH-1) ? 0 : g+1.
  - No transfer: ptr holds.
  - RR=0: ptr stays 0.
- Output drain: out_valid && out_ready with no new transfer -> out_valid<=0. out_data and out_id hold their last values; they are don't-care once out_valid=0.
- Backpressure: while out_valid && !out_ready, out_data and out_id are stable and all in_ready=0.
- Simultaneous drain and load (out_valid && out_ready && a transfer) -> out_valid stays 1 and the register takes the new word. There is no bubble.
- flush=1: in_ready all 0 that cycle; out_valid<=0 next edge; ptr unchanged. Reset has priority over flush.
- Reset mid-transfer: a word held in the output stage is discarded. Sources must re-present it.
- N_CH=1: arbitration is trivial; out_id is always 0.
- Width rule: ptr and grant are IDW bits wide. Wrap is explicit, not by overflow, so non-power-of-2 N_CH works.
- No combinational path from in_data to out_data.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. Release reset with all in_valid=0 -> out_valid stays 0.
- RR fairness: N_CH=4, RR=1, all in_valid=1 with in_data[i]=0x100+i, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; out_data 0x100..0x103 repeating; one word per cycle.
- Fixed priority: RR=0, in_valid=4'b1010, out_ready=1 -> out_id=1 every cycle. Drop in_valid[1] -> out_id=3 the next cycle.
- Backpressure: out_valid=1 with out_data=0xDEAD and out_ready=0 for 3 cycles while channels keep requesting -> out_data=0xDEAD stable, in_ready=0. Set out_ready=1 -> the next word appears the following cycle with no bubble.
- Pointer skip/wrap: N_CH=3, ptr=2, in_valid=3'b011 -> grant 0, then ptr=1. Next cycle with the same inputs -> grant 1.
- Flush: out_valid=1, pulse flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, ptr unchanged. Arbitration resumes the cycle after.
